fetch_issue_queue: RTL and testbench

//  Dual-slot instruction queue directly downstream of the frontend's decode outputs.

---
 rtl/fetch_issue_queue_pkg.sv | 23 ++
 rtl/fetch_issue_queue_if.sv | 36 +++
 rtl/fetch_queue_ram.sv | 37 +++
 rtl/fetch_issue_queue.sv | 109 ++++++++++
 tb/tb_fetch_issue_queue.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_issue_queue_pkg.sv
// Shared payload definition for the decode -> issue instruction queue.
// entry_t field order fixes the 74-bit layout used by decode, the queue and issue.
package fetch_issue_queue_pkg;

   localparam int ENTRY_W = 74;

   // MSB first: instr[73:42], pc[41:10], then single-bit flags down to invalid at bit 0
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault_fetch;
      logic        fault_page;
      logic        exec;
      logic        lsu;
      logic        branch;
      logic        mul;
      logic        div;
      logic        csr;
      logic        rd_valid;
      logic        invalid;
   } entry_t;

endpackage

// File: rtl/fetch_issue_queue_if.sv
// Handshake bundle between decode (two fetch slots), the queue and issue (two issue slots).
// slave = queue side, master = decode/issue side.
interface fetch_issue_queue_if #(
   parameter int DEPTH_W = 2
);
   import fetch_issue_queue_pkg::*;

   logic             fetch0_valid_i;
   logic             fetch1_valid_i;
   logic             fetch0_accept_o;
   logic             fetch1_accept_o;
   entry_t           fetch0_entry_i;
   entry_t           fetch1_entry_i;
   logic             issue0_valid_o;
   logic             issue1_valid_o;
   logic             issue0_accept_i;
   logic             issue1_accept_i;
   entry_t           issue0_entry_o;
   entry_t           issue1_entry_o;
   logic [DEPTH_W:0] count_o;

   modport slave (
      input  fetch0_valid_i, fetch1_valid_i, fetch0_entry_i, fetch1_entry_i,
      input  issue0_accept_i, issue1_accept_i,
      output fetch0_accept_o, fetch1_accept_o,
      output issue0_valid_o, issue1_valid_o, issue0_entry_o, issue1_entry_o, count_o
   );

   modport master (
      output fetch0_valid_i, fetch1_valid_i, fetch0_entry_i, fetch1_entry_i,
      output issue0_accept_i, issue1_accept_i,
      input  fetch0_accept_o, fetch1_accept_o,
      input  issue0_valid_o, issue1_valid_o, issue0_entry_o, issue1_entry_o, count_o
   );

endinterface

// File: rtl/fetch_queue_ram.sv
// DEPTH x ENTRY_W register file, two write ports, two asynchronous read ports.
// Write on clock edge, read combinational; no backpressure (caller never writes both ports to one address).
module fetch_queue_ram
   import fetch_issue_queue_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int DEPTH_W = 2
) (
   input  logic               clk_i,
   input  logic               wr0_vld,
   input  logic [DEPTH_W-1:0] wr0_addr,
   input  logic [ENTRY_W-1:0] wr0_dat,
   input  logic               wr1_vld,
   input  logic [DEPTH_W-1:0] wr1_addr,
   input  logic [ENTRY_W-1:0] wr1_dat,
   input  logic [DEPTH_W-1:0] rd0_addr,
   output logic [ENTRY_W-1:0] rd0_dat,
   input  logic [DEPTH_W-1:0] rd1_addr,
   output logic [ENTRY_W-1:0] rd1_dat
);

   logic [ENTRY_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr0_vld && wr0_addr == DEPTH_W'(i)) begin
            mem[i] <= wr0_dat;
         end else if (wr1_vld && wr1_addr == DEPTH_W'(i)) begin
            mem[i] <= wr1_dat;
         end
      end
   end

   assign rd0_dat = mem[rd0_addr];
   assign rd1_dat = mem[rd1_addr];

endmodule

// File: rtl/fetch_issue_queue.sv
// Dual-slot in-order instruction queue between decode and issue, flushed on branch redirect.
// Latency: a pushed entry reaches issue0 one cycle later at the earliest; no bypass.
// Backpressure: fetch accepts come from registered free space only; a full queue refuses pushes even while popping.
// Optional perf counters enabled by FETCH_ISSUE_QUEUE_PERF_EN.
module fetch_issue_queue
   import fetch_issue_queue_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int DEPTH_W = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
`ifdef FETCH_ISSUE_QUEUE_PERF_EN
   output logic [31:0] perf_full_cycles_o,
   output logic [31:0] perf_flush_drops_o,
`endif
   fetch_issue_queue_if.slave q
);

   localparam logic [DEPTH_W:0] DEPTH_C = (DEPTH_W+1)'(DEPTH);

   logic [DEPTH_W-1:0] rd_ptr;
   logic [DEPTH_W-1:0] wr_ptr;
   logic [DEPTH_W:0]   count;
   logic [DEPTH_W:0]   free;
   logic               push0, push1, pop0, pop1;
   logic [1:0]         n_push, n_pop;
   logic [DEPTH_W+1:0] count_sum;
   logic [DEPTH_W-1:0] wr1_addr;

   assign free = DEPTH_C - count;

   assign q.fetch0_accept_o = !rst_i && (free >= (DEPTH_W+1)'(1));
   assign q.fetch1_accept_o = !rst_i && (free >= (DEPTH_W+1)'(2));
   assign q.issue0_valid_o  = (count >= (DEPTH_W+1)'(1));
   assign q.issue1_valid_o  = (count >= (DEPTH_W+1)'(2));
   assign q.count_o         = count;

   assign push0 = q.fetch0_valid_i && q.fetch0_accept_o;
   assign push1 = q.fetch1_valid_i && q.fetch1_accept_o;
   // issue1 may only consume alongside issue0 to keep retirement strictly in order
   assign pop0  = q.issue0_valid_o && q.issue0_accept_i;
   assign pop1  = q.issue1_valid_o && q.issue1_accept_i && pop0;

   assign n_push    = {1'b0, push0} + {1'b0, push1};
   assign n_pop     = {1'b0, pop0} + {1'b0, pop1};
   assign count_sum = {1'b0, count} + {{DEPTH_W{1'b0}}, n_push} - {{DEPTH_W{1'b0}}, n_pop};
   assign wr1_addr  = push0 ? wr_ptr + DEPTH_W'(1) : wr_ptr;

   fetch_queue_ram #(
      .DEPTH   (DEPTH),
      .DEPTH_W (DEPTH_W)
   ) u_ram (
      .clk_i    (clk_i),
      .wr0_vld  (push0 && !flush_i),
      .wr0_addr (wr_ptr),
      .wr0_dat  (q.fetch0_entry_i),
      .wr1_vld  (push1 && !flush_i),
      .wr1_addr (wr1_addr),
      .wr1_dat  (q.fetch1_entry_i),
      .rd0_addr (rd_ptr),
      .rd0_dat  (q.issue0_entry_o),
      .rd1_addr (rd_ptr + DEPTH_W'(1)),
      .rd1_dat  (q.issue1_entry_o)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         count  <= count_sum[DEPTH_W:0];
         rd_ptr <= rd_ptr + DEPTH_W'(n_pop);
         wr_ptr <= wr_ptr + DEPTH_W'(n_push);
      end
   end

   // an underflow wraps count_sum to a large value, so one bound covers both directions
   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i) begin
         assert (count_sum <= {1'b0, DEPTH_C});
      end
   end

`ifdef FETCH_ISSUE_QUEUE_PERF_EN
   logic [32:0] drop_sum;

   assign drop_sum = {1'b0, perf_flush_drops_o} + 33'(count);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_full_cycles_o <= '0;
         perf_flush_drops_o <= '0;
      end else begin
         if (count == DEPTH_C && perf_full_cycles_o != '1) begin
            perf_full_cycles_o <= perf_full_cycles_o + 32'd1;
         end
         if (flush_i) begin
            perf_flush_drops_o <= drop_sum[32] ? '1 : drop_sum[31:0];
         end
      end
   end
`else
   // counters absent in this build; queue behaviour is unchanged
`endif

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Directed bench for fetch_issue_queue: reset, dual push/pop, full, partial accept, in-order pop, flush, streaming.
module tb_fetch_issue_queue;
   import fetch_issue_queue_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   total = 0;
   int   bad   = 0;

   initial forever #5 clk = ~clk;

   fetch_issue_queue_if #(.DEPTH_W(2)) q ();

`ifdef FETCH_ISSUE_QUEUE_PERF_EN
   logic [31:0] perf_full;
   logic [31:0] perf_drops;
`endif

   fetch_issue_queue #(
      .DEPTH   (4),
      .DEPTH_W (2)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .flush_i            (flush),
`ifdef FETCH_ISSUE_QUEUE_PERF_EN
      .perf_full_cycles_o (perf_full),
      .perf_flush_drops_o (perf_drops),
`endif
      .q                  (q)
   );

   function automatic entry_t mk(input logic [31:0] pc);
      entry_t e;
      e       = '0;
      e.instr = {16'hC0DE, pc[15:0]};
      e.pc    = pc;
      {e.fault_fetch, e.fault_page, e.exec, e.lsu, e.branch, e.mul, e.div, e.csr, e.rd_valid, e.invalid} = pc[11:2];
      return e;
   endfunction

   task automatic idle();
      q.fetch0_valid_i  = 1'b0;
      q.fetch1_valid_i  = 1'b0;
      q.fetch0_entry_i  = '0;
      q.fetch1_entry_i  = '0;
      q.issue0_accept_i = 1'b0;
      q.issue1_accept_i = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push2(input logic [31:0] pc0, input logic [31:0] pc1);
      q.fetch0_valid_i = 1'b1;
      q.fetch0_entry_i = mk(pc0);
      q.fetch1_valid_i = 1'b1;
      q.fetch1_entry_i = mk(pc1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      flush = 1'b0;
      idle();
      #1;
      total++; if (q.fetch0_accept_o !== 1'b0) begin bad++; $display("FAIL reset_acc0 got=%b exp=0", q.fetch0_accept_o); end
      total++; if (q.fetch1_accept_o !== 1'b0) begin bad++; $display("FAIL reset_acc1 got=%b exp=0", q.fetch1_accept_o); end
      tick();
      total++; if (q.count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", q.count_o); end
      total++; if (q.issue0_valid_o !== 1'b0 || q.issue1_valid_o !== 1'b0) begin bad++; $display("FAIL reset_ivalid got=%b%b exp=00", q.issue0_valid_o, q.issue1_valid_o); end
`ifdef FETCH_ISSUE_QUEUE_PERF_EN
      total++; if (perf_full !== 32'd0 || perf_drops !== 32'd0) begin bad++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_full, perf_drops); end
`endif
      rst = 1'b0;
      #1;
      total++; if (q.fetch0_accept_o !== 1'b1 || q.fetch1_accept_o !== 1'b1) begin bad++; $display("FAIL empty_acc got=%b%b exp=11", q.fetch0_accept_o, q.fetch1_accept_o); end
   endtask

   task automatic test_dual();
      push2(32'h1000, 32'h1004);
      tick(); idle(); #1;
      total++; if (q.count_o !== 3'd2) begin bad++; $display("FAIL dual_count got=%0d exp=2", q.count_o); end
      total++; if (q.issue0_valid_o !== 1'b1 || q.issue1_valid_o !== 1'b1) begin bad++; $display("FAIL dual_ivalid got=%b%b exp=11", q.issue0_valid_o, q.issue1_valid_o); end
      total++; if (q.issue0_entry_o !== mk(32'h1000)) begin bad++; $display("FAIL dual_issue0 got=%h exp=%h", q.issue0_entry_o, mk(32'h1000)); end
      total++; if (q.issue1_entry_o !== mk(32'h1004)) begin bad++; $display("FAIL dual_issue1 got=%h exp=%h", q.issue1_entry_o, mk(32'h1004)); end
      q.issue0_accept_i = 1'b1;
      q.issue1_accept_i = 1'b1;
      tick(); idle(); #1;
      total++; if (q.count_o !== 3'd0) begin bad++; $display("FAIL dual_drain got=%0d exp=0", q.count_o); end
      total++; if (q.issue0_valid_o !== 1'b0) begin bad++; $display("FAIL dual_empty_v0 got=%b exp=0", q.issue0_valid_o); end
   endtask

   task automatic test_full();
      push2(32'h1000, 32'h1004);
      tick();
      push2(32'h1008, 32'h100C);
      tick(); idle(); #1;
      total++; if (q.count_o !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", q.count_o); end
      total++; if (q.fetch0_accept_o !== 1'b0 || q.fetch1_accept_o !== 1'b0) begin bad++; $display("FAIL full_acc got=%b%b exp=00", q.fetch0_accept_o, q.fetch1_accept_o); end
      push2(32'hDEAD0, 32'hDEAD4);
      tick(); idle(); #1;
      total++; if (q.count_o !== 3'd4) begin bad++; $display("FAIL full_hold got=%0d exp=4", q.count_o); end
      total++; if (q.issue0_entry_o !== mk(32'h1000)) begin bad++; $display("FAIL full_head got=%h exp=%h", q.issue0_entry_o, mk(32'h1000)); end
      total++; if (q.issue1_entry_o !== mk(32'h1004)) begin bad++; $display("FAIL full_head1 got=%h exp=%h", q.issue1_entry_o, mk(32'h1004)); end
      // full plus pop: still refuses the push
      q.fetch0_valid_i  = 1'b1;
      q.fetch0_entry_i  = mk(32'hDEAD0);
      q.issue0_accept_i = 1'b1;
      #1;
      total++; if (q.fetch0_accept_o !== 1'b0) begin bad++; $display("FAIL full_pop_acc got=%b exp=0", q.fetch0_accept_o); end
      tick(); idle(); #1;
      total++; if (q.count_o !== 3'd3) begin bad++; $display("FAIL full_pop_count got=%0d exp=3", q.count_o); end
      total++; if (q.issue0_entry_o !== mk(32'h1004)) begin bad++; $display("FAIL full_pop_head got=%h exp=%h", q.issue0_entry_o, mk(32'h1004)); end
   endtask

   task automatic test_partial_accept();
      push2(32'h2000, 32'h2004);
      #1;
      total++; if (q.fetch0_accept_o !== 1'b1 || q.fetch1_accept_o !== 1'b0) begin bad++; $display("FAIL part_acc got=%b%b exp=10", q.fetch0_accept_o, q.fetch1_accept_o); end
      tick(); idle(); #1;
      total++; if (q.count_o !== 3'd4) begin bad++; $display("FAIL part_count got=%0d exp=4", q.count_o); end
      // pop two while re-presenting the rejected slot; pre-pop free is zero
      q.fetch0_valid_i  = 1'b1;
      q.fetch0_entry_i  = mk(32'h2004);
      q.issue0_accept_i = 1'b1;
      q.issue1_accept_i = 1'b1;
      #1;
      total++; if (q.fetch0_accept_o !== 1'b0) begin bad++; $display("FAIL part_full_acc got=%b exp=0", q.fetch0_accept_o); end
      tick(); idle(); #1;
      total++; if (q.count_o !== 3'd2) begin bad++; $display("FAIL part_pop_count got=%0d exp=2", q.count_o); end
      total++; if (q.issue0_entry_o !== mk(32'h100C) || q.issue1_entry_o !== mk(32'h2000)) begin bad++; $display("FAIL part_order got=%h/%h exp=%h/%h", q.issue0_entry_o, q.issue1_entry_o, mk(32'h100C), mk(32'h2000)); end
      q.fetch0_valid_i = 1'b1;
      q.fetch0_entry_i = mk(32'h2004);
      tick(); idle();
      q.issue0_accept_i = 1'b1;
      q.issue1_accept_i = 1'b1;
      tick(); idle(); #1;
      total++; if (q.count_o !== 3'd1) begin bad++; $display("FAIL part_left got=%0d exp=1", q.count_o); end
      total++; if (q.issue0_entry_o !== mk(32'h2004)) begin bad++; $display("FAIL part_replay got=%h exp=%h", q.issue0_entry_o, mk(32'h2004)); end
      total++; if (q.issue1_valid_o !== 1'b0) begin bad++; $display("FAIL part_v1 got=%b exp=0", q.issue1_valid_o); end
      q.issue0_accept_i = 1'b1;
      tick(); idle(); #1;
      total++; if (q.count_o !== 3'd0) begin bad++; $display("FAIL part_empty got=%0d exp=0", q.count_o); end
   endtask

   task automatic test_issue1_only();
      push2(32'h3000, 32'h3004);
      tick(); idle();
      q.issue1_accept_i = 1'b1;
      tick(); idle(); #1;
      total++; if (q.count_o !== 3'd2) begin bad++; $display("FAIL i1only_count got=%0d exp=2", q.count_o); end
      total++; if (q.issue0_entry_o !== mk(32'h3000)) begin bad++; $display("FAIL i1only_head got=%h exp=%h", q.issue0_entry_o, mk(32'h3000)); end
   endtask

   task automatic test_flush();
      q.fetch0_valid_i = 1'b1;
      q.fetch0_entry_i = mk(32'h3008);
      tick(); idle(); #1;
      total++; if (q.count_o !== 3'd3) begin bad++; $display("FAIL flush_pre got=%0d exp=3", q.count_o); end
      push2(32'h4000, 32'h4004);
      q.issue0_accept_i = 1'b1;
      flush = 1'b1;
      tick(); idle();
      flush = 1'b0;
      #1;
      total++; if (q.count_o !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", q.count_o); end
      total++; if (q.issue0_valid_o !== 1'b0 || q.issue1_valid_o !== 1'b0) begin bad++; $display("FAIL flush_ivalid got=%b%b exp=00", q.issue0_valid_o, q.issue1_valid_o); end
`ifdef FETCH_ISSUE_QUEUE_PERF_EN
      total++; if (perf_drops !== 32'd3) begin bad++; $display("FAIL perf_drops got=%0d exp=3", perf_drops); end
      total++; if (perf_full !== 32'd3) begin bad++; $display("FAIL perf_full got=%0d exp=3", perf_full); end
`endif
      q.fetch0_valid_i = 1'b1;
      q.fetch0_entry_i = mk(32'h5000);
      tick(); idle(); #1;
      total++; if (q.issue0_entry_o !== mk(32'h5000) || q.count_o !== 3'd1) begin bad++; $display("FAIL flush_refill got=%h cnt=%0d exp=%h cnt=1", q.issue0_entry_o, q.count_o, mk(32'h5000)); end
      q.issue0_accept_i = 1'b1;
      tick(); idle();
   endtask

   task automatic test_stream();
      int p   = 0;
      int c   = 0;
      int mc  = 0;
      int cyc = 0;
      logic v0, v1, a0, a1, f0, f1, pp0, pp1;
      while (c < 100 && cyc < 3000) begin
         v0 = (p < 100) && ($urandom_range(0, 3) != 0);
         v1 = v0 && (p + 1 < 100) && ($urandom_range(0, 1) != 0);
         a0 = ($urandom_range(0, 3) != 0);
         a1 = ($urandom_range(0, 1) != 0);
         q.fetch0_valid_i  = v0;
         q.fetch0_entry_i  = mk(32'(p * 4));
         q.fetch1_valid_i  = v1;
         q.fetch1_entry_i  = mk(32'((p + 1) * 4));
         q.issue0_accept_i = a0;
         q.issue1_accept_i = a1;
         #1;
         total++; if (q.count_o !== 3'(mc)) begin bad++; $display("FAIL stream_count cyc=%0d got=%0d exp=%0d", cyc, q.count_o, mc); end
         total++; if (q.fetch0_accept_o !== (mc <= 3) || q.fetch1_accept_o !== (mc <= 2)) begin bad++; $display("FAIL stream_acc cyc=%0d got=%b%b mc=%0d", cyc, q.fetch0_accept_o, q.fetch1_accept_o, mc); end
         f0  = v0 && (mc <= 3);
         f1  = v1 && (mc <= 2);
         pp0 = (mc >= 1) && a0;
         pp1 = (mc >= 2) && a1 && pp0;
         if (pp0) begin
            total++; if (q.issue0_entry_o !== mk(32'(c * 4))) begin bad++; $display("FAIL stream_pop0 cyc=%0d got=%h exp=%h", cyc, q.issue0_entry_o, mk(32'(c * 4))); end
         end
         if (pp1) begin
            total++; if (q.issue1_entry_o !== mk(32'((c + 1) * 4))) begin bad++; $display("FAIL stream_pop1 cyc=%0d got=%h exp=%h", cyc, q.issue1_entry_o, mk(32'((c + 1) * 4))); end
         end
         tick();
         p   = p + int'(f0) + int'(f1);
         c   = c + int'(pp0) + int'(pp1);
         mc  = mc + int'(f0) + int'(f1) - int'(pp0) - int'(pp1);
         cyc = cyc + 1;
      end
      idle();
      #1;
      total++; if (c != 100) begin bad++; $display("FAIL stream_timeout got=%0d consumed exp=100", c); end
      total++; if (q.count_o !== 3'd0) begin bad++; $display("FAIL stream_final_count got=%0d exp=0", q.count_o); end
   endtask

   initial begin
      test_reset();
      test_dual();
      test_full();
      test_partial_accept();
      test_issue1_only();
      test_flush();
      test_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
